// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - producer slots and register-file write port bundle
interface writeback_arbiter_if #(
  parameter int XLEN = 32,
  parameter int NSRC = 3
);
  logic [NSRC-1:0]           i_src_valid;
  logic [NSRC-1:0]           o_src_ready;
  logic [NSRC-1:0][4:0]      i_src_rd;
  logic [NSRC-1:0][XLEN-1:0] i_src_data;
  logic [4:0]                o_rd;
  logic [XLEN-1:0]           o_rd_din;
  logic                      o_reg_write;
  logic [31:0]               o_pending;

  modport slave (
    input  i_src_valid, i_src_rd, i_src_data,
    output o_src_ready, o_rd, o_rd_din, o_reg_write, o_pending
  );

  modport master (
    output i_src_valid, i_src_rd, i_src_data,
    input  o_src_ready, o_rd, o_rd_din, o_reg_write, o_pending
  );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - three-source writeback arbiter with same-rd ordering
// WB_RR_ARB_EN selects round-robin arbitration; undefined gives fixed priority 0>1>2.
module writeback_arbiter #(
  parameter int XLEN = 32,
  parameter int NSRC = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  writeback_arbiter_if.slave  wb
);
  localparam int IW = $clog2(NSRC);

  logic [NSRC-1:0]            occ_q, occ_d;
  logic [NSRC-1:0][4:0]       rd_q, rd_d;
  logic [NSRC-1:0][XLEN-1:0]  data_q, data_d;
  logic [NSRC-1:0][NSRC-1:0]  mask_q, mask_d;

  logic [NSRC-1:0]            eligible, grant, ready, acc, occ_after;
  logic [NSRC-1:0][4:0]       rd_after;
  logic                       gnt_vld;
  logic [IW-1:0]              gnt_idx;
  logic [31:0]                pend;

`ifdef WB_RR_ARB_EN
  logic [IW-1:0]              ptr_q, ptr_d;
`endif

  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      eligible[s] = occ_q[s] & (mask_q[s] == '0);
    end
  end

  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifdef WB_RR_ARB_EN
    // Search starts one past the last granted source.
    for (int k = 1; k <= NSRC; k++) begin
      j = (int'(ptr_q) + k) % NSRC;
      if (!gnt_vld && eligible[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    ptr_d = gnt_vld ? gnt_idx : ptr_q;
`else
    for (int s = 0; s < NSRC; s++) begin
      if (!gnt_vld && eligible[s]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(s);
      end
    end
`endif
    grant = '0;
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  assign ready = {NSRC{~i_rst}} & (~occ_q | grant);
  assign acc   = wb.i_src_valid & ready;

  always_comb begin
    for (int t = 0; t < NSRC; t++) begin
      occ_after[t] = acc[t] | (occ_q[t] & ~grant[t]);
      rd_after[t]  = acc[t] ? wb.i_src_rd[t] : rd_q[t];
    end
  end

  always_comb begin
    occ_d  = occ_q;
    rd_d   = rd_q;
    data_d = data_q;
    mask_d = mask_q;
    for (int s = 0; s < NSRC; s++) begin
      if (acc[s]) begin
        occ_d[s]  = 1'b1;
        rd_d[s]   = wb.i_src_rd[s];
        data_d[s] = wb.i_src_data[s];
        // Younger same-cycle arrivals (higher index) never block an older one.
        for (int t = 0; t < NSRC; t++) begin
          mask_d[s][t] = (t != s) && occ_after[t] &&
                         (rd_after[t] == wb.i_src_rd[s]) && !(acc[t] && (t > s));
        end
      end else if (grant[s]) begin
        occ_d[s]  = 1'b0;
        mask_d[s] = '0;
      end else begin
        mask_d[s] = mask_q[s] & ~grant;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      occ_q  <= '0;
      rd_q   <= '0;
      data_q <= '0;
      mask_q <= '0;
`ifdef WB_RR_ARB_EN
      ptr_q  <= IW'(NSRC - 1);
`endif
    end else begin
      occ_q  <= occ_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      mask_q <= mask_d;
`ifdef WB_RR_ARB_EN
      ptr_q  <= ptr_d;
`endif
    end
  end

  always_comb begin
    pend = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (occ_q[s]) pend[rd_q[s]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign wb.o_src_ready = ready;
  assign wb.o_pending   = pend;
  assign wb.o_rd        = gnt_vld ? rd_q[gnt_idx] : 5'd0;
  assign wb.o_rd_din    = gnt_vld ? data_q[gnt_idx] : '0;
  assign wb.o_reg_write = gnt_vld && (rd_q[gnt_idx] != 5'd0);
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  writeback_arbiter_if #(.XLEN(32), .NSRC(3)) wb ();

  writeback_arbiter #(.XLEN(32), .NSRC(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .wb    (wb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.i_src_valid = '0;
    wb.i_src_rd    = '0;
    wb.i_src_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({wb.o_reg_write, wb.o_rd, wb.o_rd_din, wb.o_pending, wb.o_src_ready} !== '0)
      $display("FAIL reset_outputs: we=%b rd=%0d din=%h pend=%h rdy=%b required all zero",
               wb.o_reg_write, wb.o_rd, wb.o_rd_din, wb.o_pending, wb.o_src_ready);
    else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (wb.o_src_ready !== 3'b111)
      $display("FAIL reset_release_ready: got %b required 111", wb.o_src_ready);
    else n_pass++;
  endtask

  task automatic test_single_write();
    do_reset();
    wb.i_src_valid = 3'b010;
    wb.i_src_rd[1] = 5'd5;
    wb.i_src_data[1] = 32'hDEADBEEF;
    tick();
    idle_inputs();
    n_checks++;
    if (wb.o_pending !== 32'h0000_0020)
      $display("FAIL single_pending: got %h required 00000020", wb.o_pending);
    else n_pass++;
    n_checks++;
    if ({wb.o_reg_write, wb.o_rd, wb.o_rd_din} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL single_port: we=%b rd=%0d din=%h required we=1 rd=5 din=deadbeef",
               wb.o_reg_write, wb.o_rd, wb.o_rd_din);
    else n_pass++;
    tick();
    n_checks++;
    if ({wb.o_reg_write, wb.o_pending} !== {1'b0, 32'h0})
      $display("FAIL single_drained: we=%b pend=%h required we=0 pend=0",
               wb.o_reg_write, wb.o_pending);
    else n_pass++;
  endtask

  task automatic test_same_rd();
    do_reset();
    wb.i_src_valid = 3'b101;
    wb.i_src_rd[0] = 5'd7;
    wb.i_src_data[0] = 32'h1;
    wb.i_src_rd[2] = 5'd7;
    wb.i_src_data[2] = 32'h2;
    tick();
    idle_inputs();
    n_checks++;
    if ({wb.o_reg_write, wb.o_rd, wb.o_rd_din} !== {1'b1, 5'd7, 32'h1})
      $display("FAIL same_rd_first: we=%b rd=%0d din=%h required we=1 rd=7 din=1",
               wb.o_reg_write, wb.o_rd, wb.o_rd_din);
    else n_pass++;
    n_checks++;
    if (wb.o_src_ready !== 3'b011)
      $display("FAIL same_rd_ready: got %b required 011", wb.o_src_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({wb.o_reg_write, wb.o_rd, wb.o_rd_din} !== {1'b1, 5'd7, 32'h2})
      $display("FAIL same_rd_second: we=%b rd=%0d din=%h required we=1 rd=7 din=2",
               wb.o_reg_write, wb.o_rd, wb.o_rd_din);
    else n_pass++;
    tick();
    n_checks++;
    if ({wb.o_reg_write, wb.o_pending} !== {1'b0, 32'h0})
      $display("FAIL same_rd_done: we=%b pend=%h required we=0 pend=0",
               wb.o_reg_write, wb.o_pending);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [4:0]  exp_rd  [4];
    logic [31:0] exp_din [4];
    logic [2:0]  exp_rdy [4];
`ifdef WB_RR_ARB_EN
    exp_rd[0] = 5'd1; exp_rd[1] = 5'd2; exp_rd[2] = 5'd3; exp_rd[3] = 5'd1;
    exp_din[0] = 32'hA0; exp_din[1] = 32'hB0; exp_din[2] = 32'hC0; exp_din[3] = 32'hA0;
    exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100; exp_rdy[3] = 3'b001;
`else
    for (int i = 0; i < 4; i++) begin
      exp_rd[i] = 5'd1;
      exp_din[i] = 32'hA0;
      exp_rdy[i] = 3'b001;
    end
`endif
    do_reset();
    wb.i_src_valid = 3'b111;
    wb.i_src_rd[0] = 5'd1; wb.i_src_data[0] = 32'hA0;
    wb.i_src_rd[1] = 5'd2; wb.i_src_data[1] = 32'hB0;
    wb.i_src_rd[2] = 5'd3; wb.i_src_data[2] = 32'hC0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({wb.o_reg_write, wb.o_rd, wb.o_rd_din, wb.o_src_ready} !==
          {1'b1, exp_rd[c], exp_din[c], exp_rdy[c]})
        $display("FAIL contention_c%0d: we=%b rd=%0d din=%h rdy=%b required we=1 rd=%0d din=%h rdy=%b",
                 c, wb.o_reg_write, wb.o_rd, wb.o_rd_din, wb.o_src_ready,
                 exp_rd[c], exp_din[c], exp_rdy[c]);
      else n_pass++;
    end
    n_checks++;
    if (wb.o_pending !== 32'h0000_000E)
      $display("FAIL contention_pending: got %h required 0000000e", wb.o_pending);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_x0_discard();
    do_reset();
    wb.i_src_valid = 3'b001;
    wb.i_src_rd[0] = 5'd0;
    wb.i_src_data[0] = 32'hFFFF;
    tick();
    idle_inputs();
    n_checks++;
    if ({wb.o_reg_write, wb.o_rd, wb.o_pending, wb.o_src_ready} !== {1'b0, 5'd0, 32'h0, 3'b111})
      $display("FAIL x0_granted: we=%b rd=%0d pend=%h rdy=%b required we=0 rd=0 pend=0 rdy=111",
               wb.o_reg_write, wb.o_rd, wb.o_pending, wb.o_src_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({wb.o_reg_write, wb.o_rd_din} !== {1'b0, 32'h0})
      $display("FAIL x0_drained: we=%b din=%h required we=0 din=0", wb.o_reg_write, wb.o_rd_din);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      wb.i_src_valid = 3'b001;
      wb.i_src_rd[0] = 5'(k);
      wb.i_src_data[0] = 32'h100 + 32'(k);
      tick();
      n_checks++;
      if ({wb.o_src_ready[0], wb.o_reg_write, wb.o_rd, wb.o_rd_din} !==
          {1'b1, 1'b1, 5'(k), 32'h100 + 32'(k)})
        $display("FAIL b2b_w%0d: rdy0=%b we=%b rd=%0d din=%h required rdy0=1 we=1 rd=%0d din=%h",
                 k, wb.o_src_ready[0], wb.o_reg_write, wb.o_rd, wb.o_rd_din, k, 32'h100 + 32'(k));
      else n_pass++;
    end
    idle_inputs();
    tick();
    n_checks++;
    if (wb.o_reg_write !== 1'b0)
      $display("FAIL b2b_end: we=%b required 0", wb.o_reg_write);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    wb.i_src_valid = 3'b111;
    wb.i_src_rd[0] = 5'd10; wb.i_src_data[0] = 32'h10;
    wb.i_src_rd[1] = 5'd11; wb.i_src_data[1] = 32'h11;
    wb.i_src_rd[2] = 5'd12; wb.i_src_data[2] = 32'h12;
    tick();
    idle_inputs();
    n_checks++;
    if (wb.o_pending !== 32'h0000_1C00)
      $display("FAIL async_filled: pend=%h required 00001c00", wb.o_pending);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({wb.o_reg_write, wb.o_rd, wb.o_rd_din, wb.o_pending, wb.o_src_ready} !== '0)
      $display("FAIL async_assert: we=%b rd=%0d din=%h pend=%h rdy=%b required all zero",
               wb.o_reg_write, wb.o_rd, wb.o_rd_din, wb.o_pending, wb.o_src_ready);
    else n_pass++;
    tick();
    #3;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({wb.o_reg_write, wb.o_pending, wb.o_src_ready} !== {1'b0, 32'h0, 3'b111})
        $display("FAIL async_stale_c%0d: we=%b pend=%h rdy=%b required we=0 pend=0 rdy=111",
                 c, wb.o_reg_write, wb.o_pending, wb.o_src_ready);
      else n_pass++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_same_rd();
    test_contention();
    test_x0_discard();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
